uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the write port of the UART TX FIFO (8-bit data, wr_en/full interface) between N byte-stream requesters, e.g. a command responder, a status reporter and a debug tap.
- Grants are message-atomic: the owner keeps the FIFO until it sends a byte flagged last, hits the burst limit, or goes idle past a timeout.
- Sits between the requesters and the TX FIFO; the FIFO's read side feeds the UART transmitter unchanged.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- D_BITS, 8, data width; must match the FIFO data width.
- MAX_BURST, 16, maximum bytes per grant; 0 = unlimited.
- TIMEOUT, 32, consecutive granted cycles with owner req_valid low before forced release; 0 = disabled.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*D_BITS  per-requester byte; requester i occupies bits [i*D_BITS +: D_BITS].
- req_last  in  N_REQ  marks the final byte of a message.
- req_ready  out  N_REQ  per-requester accept.
- fifo_din  out  D_BITS  data to FIFO din.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_full  in  1  FIFO full flag.
- grant_id  out  clog2(N_REQ)  current owner index.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, grant_id=0, byte_cnt=0, idle_cnt=0. All outputs 0: req_ready, fifo_wr_en, fifo_din, busy.
- States are IDLE and GRANT.
- IDLE:
  - If any req_valid is high, pick the first asserted index searching from rr_ptr upward, modulo N_REQ.
  - Next edge: grant_id←winner, state←GRANT, byte_cnt←0, idle_cnt←0.
  - No transfer occurs in IDLE. Valid-to-first-write latency is 1 cycle.
- GRANT, with g=grant_id:
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en = req_valid[g] & ~fifo_full. fifo_din = req_data[g], and 0 whenever fifo_wr_en is low.
  - A transfer is a cycle with fifo_wr_en=1. fifo_wr_en must never be high while fifo_full=1.
  - On each transfer: byte_cnt+1, idle_cnt←0.
  - In a cycle with req_valid[g]=0: idle_cnt+1, saturating.
  - fifo_full high with valid high is a stall: neither counter changes.
- Release conditions. Evaluated at the clock edge; any one returns state to IDLE and sets rr_ptr←(g+1) mod N_REQ:
  - A transfer with req_last[g]=1.
  - A transfer that makes byte_cnt equal MAX_BURST, when MAX_BURST≠0.
  - idle_cnt reaches TIMEOUT, when TIMEOUT≠0.
- Priority: a last byte and the burst limit on the same transfer cause a single release.
- Release always passes through one IDLE cycle. No back-to-back grants without that bubble.
- A requester deasserting valid mid-message keeps the grant until the timeout.
- Arbitration fairness: a requester continuously asserting valid is granted within N_REQ-1 other grants.
- Data or last changing while ready=0 is ignored. Only the transfer cycle is sampled.
- Reset mid-GRANT: the partial message is abandoned. The FIFO is not written after reset assertion, and outputs go to 0 immediately.
- byte_cnt width is clog2(MAX_BURST+1) and idle_cnt width is clog2(TIMEOUT+1); both have a minimum of 1 bit.

Test Plan:
- Single requester 1 sends 3 bytes 0xA1,0xA2,0xA3, last on 0xA3, FIFO empty -> grant_id=1 one cycle after valid; 3 consecutive wr_en with din in order; IDLE the next cycle; rr_ptr=2.
- Requesters 0,2,3 all valid continuously, 1-byte messages each with last=1 -> grant order 0,2,3,0,2,3, with one IDLE cycle between grants.
- MAX_BURST=4, requester 0 streams 10 bytes with no last, requester 1 valid -> release after 4 bytes, requester 1 granted next, requester 0 resumes later; total FIFO bytes are in the correct per-source order.
- fifo_full asserted for 5 cycles mid-message -> wr_en=0 and req_ready[g]=0 throughout; byte_cnt and idle_cnt frozen; transfer resumes with the same pending byte on the first non-full cycle.
- TIMEOUT=32, owner drops valid after 2 bytes -> released after exactly 32 idle cycles; another waiting requester is granted on the next arbitration.
- reset_n pulsed low mid-GRANT -> all outputs 0 asynchronously; after release, first grant searches from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle of the requester byte streams and the TX FIFO write port that the
//   uart_tx_arbiter sits between.
//
//   Handshake: a byte moves from requester i to the FIFO in a cycle where
//   req_valid[i] and req_ready[i] are both high; that same cycle fifo_wr_en
//   is high and fifo_din carries the byte. req_ready never rises while
//   fifo_full is high, and data/last are only sampled in a transfer cycle.
//
//   Signals:
//     req_valid  [N_REQ]         per-requester byte valid
//     req_data   [N_REQ*D_BITS]  requester i at [i*D_BITS +: D_BITS]
//     req_last   [N_REQ]         final byte of a message
//     req_ready  [N_REQ]         per-requester accept
//     fifo_din   [D_BITS]        byte written into the TX FIFO
//     fifo_wr_en                 TX FIFO write enable
//     fifo_full                  TX FIFO full flag
//
//   Modports:
//     slave  - the arbiter
//     master - the surroundings (requesters and FIFO)
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int D_BITS = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*D_BITS-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [D_BITS-1:0]       fifo_din;
    logic                    fifo_wr_en;
    logic                    fifo_full;

    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_din, fifo_wr_en
    );

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_din, fifo_wr_en
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin, message-atomic arbiter sharing the UART TX FIFO write port
//   between N_REQ byte-stream requesters. The owner keeps the FIFO until it
//   transfers a byte flagged last, reaches MAX_BURST bytes (0 = unlimited),
//   or stays idle for TIMEOUT granted cycles (0 = never). Every release goes
//   through one IDLE cycle before the next grant.
//
//   Ports:
//     clk        clock
//     reset_n    asynchronous, active-low reset
//     bus        uart_tx_arbiter_if.slave (requester streams + FIFO port)
//     grant_id   index of the current / most recent owner
//     busy       high while a requester owns the FIFO
//     state_dbg  raw FSM state (0 = IDLE, 1 = GRANT)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_BITS    = 8,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 32,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_tx_arbiter_if.slave     bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 state_dbg
);

    localparam int BC_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam int IC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [BC_W-1:0] byte_cnt, byte_cnt_nxt;
    logic [IC_W-1:0] idle_cnt, idle_cnt_nxt;

    logic [GW-1:0]     winner;
    logic              any_valid;
    logic              own_valid;
    logic              own_last;
    logic [D_BITS-1:0] own_data;
    logic              xfer;
    logic              release_grant;

    assign state_dbg = state;

    // Round-robin search starting at rr_ptr. The loop walks offsets from the
    // far end down so the lowest offset with valid set is the final winner.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (bus.req_valid[idx]) begin
                winner    = GW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign own_valid = bus.req_valid[grant_id];
    assign own_last  = bus.req_last[grant_id];
    assign own_data  = bus.req_data[int'(grant_id)*D_BITS +: D_BITS];

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_id;
        rr_ptr_nxt     = rr_ptr;
        byte_cnt_nxt   = byte_cnt;
        idle_cnt_nxt   = idle_cnt;
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_din   = '0;
        busy           = 1'b0;
        xfer           = 1'b0;
        release_grant  = 1'b0;

        case (state)
            IDLE: begin
                // Arbitration only; nothing is written to the FIFO here.
                if (any_valid) begin
                    grant_nxt    = winner;
                    state_nxt    = GRANT;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end

            GRANT: begin
                busy                    = 1'b1;
                bus.req_ready[grant_id] = ~bus.fifo_full;
                xfer                    = own_valid & ~bus.fifo_full;
                bus.fifo_wr_en          = xfer;
                bus.fifo_din            = xfer ? own_data : '0;

                if (xfer) begin
                    byte_cnt_nxt = byte_cnt + 1'b1;
                    idle_cnt_nxt = '0;
                    // A last byte that also hits the burst limit is one release.
                    if (own_last) begin
                        release_grant = 1'b1;
                    end
                    if ((MAX_BURST != 0) && (byte_cnt_nxt == BC_W'(MAX_BURST))) begin
                        release_grant = 1'b1;
                    end
                end else if (!own_valid) begin
                    if (idle_cnt != {IC_W{1'b1}}) begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                    if ((TIMEOUT != 0) && (idle_cnt_nxt == IC_W'(TIMEOUT))) begin
                        release_grant = 1'b1;
                    end
                end
                // Otherwise valid is high against a full FIFO: a stall, so
                // both counters hold.

                if (release_grant) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            grant_id <= grant_nxt;
            byte_cnt <= byte_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N_REQ=4, D_BITS=8, MAX_BURST=4,
//   TIMEOUT=32): a directed vector table, hand-written multi-cycle sequences
//   and a randomized phase compared against a cycle-level reference model
//   built from the arbitration rules, plus a byte scoreboard.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int MB = 4;
    localparam int TO = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset_n;
    logic [1:0] grant_id;
    logic busy;
    logic state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .D_BITS(D)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N), .D_BITS(D), .MAX_BURST(MB), .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .grant_id (grant_id),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- reference model state ----------------
    bit m_busy;
    int m_gid, m_ptr, m_bytes, m_idle;

    // scoreboard of bytes the FIFO should receive, in order
    logic [D-1:0] exp_q[$];

    // requester message queues: {last, data}
    logic [8:0] src_q[N][$];
    int vprob = 100;

    // grant monitor
    int g_ids[$];
    int g_cnt[$];
    bit prev_busy;

    // values sampled during the latest step
    logic       s_wr, s_busy;
    logic [7:0] s_din;
    logic [3:0] s_rdy;
    logic [1:0] s_gid;

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gid = 0; m_ptr = 0; m_bytes = 0; m_idle = 0;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        prev_busy = 0;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < vprob) begin
                bus.req_valid[i]       = 1'b1;
                bus.req_data[i*D +: D] = src_q[i][0][7:0];
                bus.req_last[i]        = src_q[i][0][8];
            end else begin
                bus.req_valid[i]       = 1'b0;
                bus.req_data[i*D +: D] = 8'($urandom);
                bus.req_last[i]        = 1'($urandom);
            end
        end
    endtask

    task automatic push_msg(input int i, input int len, input bit with_last, input logic [7:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : base + 8'(k);
            src_q[i].push_back({(with_last && k == len - 1), b});
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        bus.fifo_full = 1'b0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One clock: inputs already applied; compare at negedge, advance model,
    // then move to just after the next rising edge and drive new inputs.
    task automatic step();
        logic [3:0] e_rdy;
        logic       e_wr;
        logic [7:0] e_din;
        int g, idx;
        bit rel, found;
        @(negedge clk);
        e_rdy = '0; e_wr = 0; e_din = '0; g = m_gid;
        if (m_busy) begin
            e_rdy = bus.fifo_full ? 4'b0 : 4'(1 << g);
            e_wr  = bus.req_valid[g] & ~bus.fifo_full;
            if (e_wr) e_din = bus.req_data[g*D +: D];
        end
        s_wr = bus.fifo_wr_en; s_din = bus.fifo_din; s_rdy = bus.req_ready;
        s_busy = busy; s_gid = grant_id;
        check("wr_en",    s_wr,   e_wr);
        check("fifo_din", s_din,  e_din);
        check("req_ready", s_rdy, e_rdy);
        check("grant_id", s_gid,  32'(m_gid));
        check("busy",     s_busy, m_busy);

        // scoreboard
        if (e_wr) exp_q.push_back(e_din);
        if (s_wr) begin
            if (exp_q.size() == 0) check("sb_unexpected_write", s_wr, 1'b0);
            else check("sb_byte", s_din, exp_q.pop_front());
        end

        // grant monitor
        if (s_busy && !prev_busy) begin
            g_ids.push_back(int'(s_gid));
            g_cnt.push_back(0);
        end
        if (s_wr && g_cnt.size() > 0) g_cnt[g_cnt.size()-1]++;
        prev_busy = s_busy;

        // requesters retire accepted bytes
        for (int i = 0; i < N; i++)
            if (e_rdy[i] && bus.req_valid[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());

        // model advance
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && bus.req_valid[idx]) begin
                    found = 1; m_gid = idx; m_busy = 1; m_bytes = 0; m_idle = 0;
                end
            end
        end else begin
            rel = 0;
            if (e_wr) begin
                m_bytes++; m_idle = 0;
                if (bus.req_last[g]) rel = 1;
                if (MB != 0 && m_bytes == MB) rel = 1;
            end else if (!bus.req_valid[g]) begin
                m_idle++;
                if (TO != 0 && m_idle >= TO) rel = 1;
            end
            if (rel) begin
                m_busy = 0;
                m_ptr  = (g + 1) % N;
            end
        end

        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int bound, input string name);
        int n = 0;
        vprob = 100;
        bus.fifo_full = 1'b0;
        drive();
        while ((pending() || m_busy) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) fail_now(name);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic        exp_wr;
        logic [7:0]  exp_din;
        logic [3:0]  exp_rdy;
        logic [1:0]  exp_gid;
        logic        exp_busy;
    } vec_t;

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l, logic f,
                                logic w, logic [7:0] di, logic [3:0] r, logic [1:0] g, logic b);
        vec_t t;
        t.valid = v; t.data = d; t.last = l; t.full = f;
        t.exp_wr = w; t.exp_din = di; t.exp_rdy = r; t.exp_gid = g; t.exp_busy = b;
        return t;
    endfunction

    vec_t tbl[15];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // requester 1 sends A1,A2,A3 (last on A3); then 0,2,3 hold 1-byte
        // messages continuously, with one full cycle on a grant.
        tbl[0]  = mk(4'b0010, 32'h0000A100, 4'b0000, 0, 0, 8'h00, 4'b0000, 2'd0, 0);
        tbl[1]  = mk(4'b0010, 32'h0000A100, 4'b0000, 0, 1, 8'hA1, 4'b0010, 2'd1, 1);
        tbl[2]  = mk(4'b0010, 32'h0000A200, 4'b0000, 0, 1, 8'hA2, 4'b0010, 2'd1, 1);
        tbl[3]  = mk(4'b0010, 32'h0000A300, 4'b0010, 0, 1, 8'hA3, 4'b0010, 2'd1, 1);
        tbl[4]  = mk(4'b0000, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000, 2'd1, 0);
        tbl[5]  = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 0, 8'h00, 4'b0000, 2'd1, 0);
        tbl[6]  = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 1, 8'hB2, 4'b0100, 2'd2, 1);
        tbl[7]  = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 0, 8'h00, 4'b0000, 2'd2, 0);
        tbl[8]  = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 1, 8'hB3, 4'b1000, 2'd3, 1);
        tbl[9]  = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 0, 8'h00, 4'b0000, 2'd3, 0);
        tbl[10] = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 1, 8'hB0, 4'b0001, 2'd0, 1);
        tbl[11] = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 0, 8'h00, 4'b0000, 2'd0, 0);
        tbl[12] = mk(4'b1101, 32'hB3B200B0, 4'b1111, 1, 0, 8'h00, 4'b0000, 2'd2, 1);
        tbl[13] = mk(4'b1101, 32'hB3B200B0, 4'b1111, 0, 1, 8'hB2, 4'b0100, 2'd2, 1);
        tbl[14] = mk(4'b0000, 32'h00000000, 4'b0000, 0, 0, 8'h00, 4'b0000, 2'd2, 0);

        // ---- reset state, with all requesters asking ----
        reset_n = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h11223344;
        bus.req_last  = 4'b1111;
        bus.fifo_full = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        check("rst_wr_en", bus.fifo_wr_en, 1'b0);
        check("rst_din",   bus.fifo_din,   8'h00);
        check("rst_ready", bus.req_ready,  4'b0000);
        check("rst_busy",  busy,           1'b0);
        check("rst_gid",   grant_id,       2'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < 15; i++) begin
            bus.req_valid = tbl[i].valid;
            bus.req_data  = tbl[i].data;
            bus.req_last  = tbl[i].last;
            bus.fifo_full = tbl[i].full;
            @(negedge clk);
            check($sformatf("tbl%0d_wr", i),    bus.fifo_wr_en, tbl[i].exp_wr);
            check($sformatf("tbl%0d_din", i),   bus.fifo_din,   tbl[i].exp_din);
            check($sformatf("tbl%0d_ready", i), bus.req_ready,  tbl[i].exp_rdy);
            check($sformatf("tbl%0d_gid", i),   grant_id,       tbl[i].exp_gid);
            check($sformatf("tbl%0d_busy", i),  busy,           tbl[i].exp_busy);
            @(posedge clk);
            #1;
        end

        // ---- burst limit: req0 streams 10 bytes, req1 has a 2-byte message ----
        apply_reset();
        g_ids.delete(); g_cnt.delete();
        push_msg(0, 10, 0, 8'h00, 0);
        push_msg(1, 2, 1, 8'h10, 0);
        drain(300, "burst_drain");
        check("burst_n_grants", g_ids.size(), 4);
        begin
            int eid[4] = '{0, 1, 0, 0};
            int ecn[4] = '{4, 2, 4, 2};
            for (int k = 0; k < 4; k++) begin
                if (k < g_ids.size()) begin
                    check($sformatf("burst_grant%0d_id", k),    g_ids[k], eid[k]);
                    check($sformatf("burst_grant%0d_bytes", k), g_cnt[k], ecn[k]);
                end
            end
        end

        // ---- FIFO full for 5 cycles mid-message ----
        apply_reset();
        push_msg(2, 4, 1, 8'h20, 0);
        drive();
        for (int t = 0; t < 12; t++) begin
            bus.fifo_full = (t >= 3 && t < 8);
            step();
            if (t >= 3 && t < 8) begin
                check("stall_wr",   s_wr,     1'b0);
                check("stall_rdy2", s_rdy[2], 1'b0);
            end
            if (t == 8) begin
                check("stall_resume_wr",   s_wr,  1'b1);
                check("stall_resume_byte", s_din, 8'h22);
            end
        end
        drain(50, "stall_drain");

        // ---- timeout: req3 drops valid after 2 bytes, req0 waiting ----
        apply_reset();
        push_msg(3, 2, 0, 8'h30, 0);
        drive();
        step();
        push_msg(0, 1, 1, 8'h40, 0);
        drive();
        begin
            int n = 0;
            int idle = 0;
            do begin
                step();
                n++;
                if (s_busy && !s_wr) idle++;
            end while (s_busy && n < 100);
            if (n >= 100) fail_now("timeout_release");
            check("timeout_idle_cycles", idle, TO);
            step();
            check("timeout_next_busy", s_busy, 1'b1);
            check("timeout_next_gid",  s_gid,  2'd0);
        end
        drain(50, "timeout_drain");

        // ---- reset pulsed mid-grant ----
        apply_reset();
        push_msg(2, 1, 1, 8'h50, 0);
        drive();
        repeat (3) step();
        push_msg(1, 5, 0, 8'h60, 0);
        drive();
        repeat (3) step();
        #2 reset_n = 1'b0;
        #1;
        check("amid_rst_wr_en", bus.fifo_wr_en, 1'b0);
        check("amid_rst_din",   bus.fifo_din,   8'h00);
        check("amid_rst_ready", bus.req_ready,  4'b0000);
        check("amid_rst_busy",  busy,           1'b0);
        check("amid_rst_gid",   grant_id,       2'd0);
        model_reset();
        drive();
        @(posedge clk);
        #1 reset_n = 1'b1;
        push_msg(3, 1, 1, 8'h70, 0);
        push_msg(0, 1, 1, 8'h71, 0);
        drive();
        step();
        step();
        check("post_rst_gid",  s_gid,  2'd0);
        check("post_rst_busy", s_busy, 1'b1);
        drain(50, "post_rst_drain");

        // ---- randomized traffic ----
        apply_reset();
        vprob = 75;
        for (int c = 0; c < 3000; c++) begin
            bus.fifo_full = ($urandom_range(99) < 20);
            for (int i = 0; i < N; i++)
                if (src_q[i].size() == 0 && $urandom_range(99) < 10)
                    push_msg(i, $urandom_range(6, 1), ($urandom_range(99) < 80), 8'h00, 1);
            drive();
            step();
        end
        drain(2000, "random_drain");
        check("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
